// File: rtl/match_run_detector.sv
// match_run_detector: tracks runs of consecutive comparator matches on valid
// cycles, raises a lock indication once a run reaches RUN_LEN, and keeps a
// saturating count of all valid matches. All outputs are registered.
module match_run_detector #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 4,
  parameter int TOT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z,
  input  logic             z_valid,
  input  logic             clear,
  output logic [CNT_W-1:0] run_cnt,
  output logic             locked,
  output logic             lock_pulse,
  output logic             mismatch_pulse,
  output logic [TOT_W-1:0] total_match
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RUN_TGT = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] run_nxt;
  logic [CNT_W-1:0] run_inc;
  logic [TOT_W-1:0] tot_nxt;
  logic             lp_nxt, mp_nxt;

  assign run_inc = run_cnt + ONE;

  // Next-state, next counter values and pulse decode.
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    tot_nxt   = total_match;
    lp_nxt    = 1'b0;
    mp_nxt    = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      run_nxt   = '0;
      tot_nxt   = '0;
    end else begin
      if (z_valid && z && (total_match != '1)) begin
        tot_nxt = total_match + TOT_W'(1);
      end
      case (state)
        IDLE: begin
          if (z_valid) begin
            if (z) begin
              run_nxt = ONE;
              if (RUN_TGT == ONE) begin
                state_nxt = LOCK;
                lp_nxt    = 1'b1;
              end else begin
                state_nxt = RUN;
              end
            end else begin
              run_nxt = '0;
            end
          end
        end
        RUN: begin
          if (z_valid) begin
            if (z) begin
              run_nxt = run_inc;
              if (run_inc == RUN_TGT) begin
                state_nxt = LOCK;
                lp_nxt    = 1'b1;
              end
            end else begin
              state_nxt = IDLE;
              run_nxt   = '0;
              mp_nxt    = 1'b1;
            end
          end
        end
        LOCK: begin
          if (z_valid) begin
            if (z) begin
              if (run_cnt != '1) run_nxt = run_inc;
            end else begin
              state_nxt = IDLE;
              run_nxt   = '0;
              mp_nxt    = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          run_nxt   = '0;
        end
      endcase
    end
  end

  // State and registered outputs; locked mirrors the next state so it rises
  // and falls on the same edge as the corresponding pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      run_cnt        <= '0;
      total_match    <= '0;
      locked         <= 1'b0;
      lock_pulse     <= 1'b0;
      mismatch_pulse <= 1'b0;
    end else begin
      state          <= state_nxt;
      run_cnt        <= run_nxt;
      total_match    <= tot_nxt;
      locked         <= (state_nxt == LOCK);
      lock_pulse     <= lp_nxt;
      mismatch_pulse <= mp_nxt;
    end
  end

endmodule

// File: tb/tb_match_run_detector.sv
// Testbench for match_run_detector: three parameterisations share one
// stimulus stream; a run-length reference model predicts each, a monitor
// compares at the falling edge.
module tb_match_run_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       z = 1'b0;
  logic       z_valid = 1'b0;
  logic       clear = 1'b0;

  logic [3:0] run_cnt0;
  logic [1:0] run_cnt1;
  logic [3:0] run_cnt2;
  logic [7:0] total0;
  logic [2:0] total1;
  logic [7:0] total2;
  logic       lk0, lk1, lk2, lp0, lp1, lp2, mp0, mp1, mp2;

  always #5 clk = ~clk;

  match_run_detector #(.RUN_LEN(3), .CNT_W(4), .TOT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .z(z), .z_valid(z_valid), .clear(clear),
    .run_cnt(run_cnt0), .locked(lk0), .lock_pulse(lp0),
    .mismatch_pulse(mp0), .total_match(total0));

  match_run_detector #(.RUN_LEN(3), .CNT_W(2), .TOT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .z(z), .z_valid(z_valid), .clear(clear),
    .run_cnt(run_cnt1), .locked(lk1), .lock_pulse(lp1),
    .mismatch_pulse(mp1), .total_match(total1));

  match_run_detector #(.RUN_LEN(1), .CNT_W(4), .TOT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .z(z), .z_valid(z_valid), .clear(clear),
    .run_cnt(run_cnt2), .locked(lk2), .lock_pulse(lp2),
    .mismatch_pulse(mp2), .total_match(total2));

  typedef struct {
    int rc;
    int lk;
    int lp;
    int mp;
    int tm;
  } exp_t;

  int   RL[3] = '{3, 3, 1};
  int   CW[3] = '{4, 2, 4};
  int   TW[3] = '{8, 3, 8};
  int   run_m[3];
  int   tot_m[3];
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input int act, input int ex);
    n_tests++;
    if (act != ex) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, ex, $time);
    end
  endtask

  // Reference: an unbounded run length and total, clipped on observation.
  function automatic exp_t model(input int i, input bit v, input bit zz, input bit clr);
    exp_t e;
    int   rmax;
    int   tmax;
    e.lp = 0;
    e.mp = 0;
    if (clr) begin
      run_m[i] = 0;
      tot_m[i] = 0;
    end else if (v) begin
      if (zz) begin
        run_m[i]++;
        tot_m[i]++;
        if (run_m[i] == RL[i]) e.lp = 1;
      end else begin
        if (run_m[i] > 0) e.mp = 1;
        run_m[i] = 0;
      end
    end
    rmax = (1 << CW[i]) - 1;
    tmax = (1 << TW[i]) - 1;
    e.rc = (run_m[i] > rmax) ? rmax : run_m[i];
    e.tm = (tot_m[i] > tmax) ? tmax : tot_m[i];
    e.lk = (run_m[i] >= RL[i]) ? 1 : 0;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input int rc, input int lk,
                     input int lp, input int mp, input int tm);
    chk({tag, ".run_cnt"}, rc, e.rc);
    chk({tag, ".locked"}, lk, e.lk);
    chk({tag, ".lock_pulse"}, lp, e.lp);
    chk({tag, ".mismatch_pulse"}, mp, e.mp);
    chk({tag, ".total_match"}, tm, e.tm);
  endtask

  // Monitor: outputs are presented every cycle; pop and compare mid-cycle.
  always @(negedge clk) begin
    if (q0.size() > 0) cmp("dut0", q0.pop_front(), int'(run_cnt0), int'(lk0), int'(lp0), int'(mp0), int'(total0));
    if (q1.size() > 0) cmp("dut1", q1.pop_front(), int'(run_cnt1), int'(lk1), int'(lp1), int'(mp1), int'(total1));
    if (q2.size() > 0) cmp("dut2", q2.pop_front(), int'(run_cnt2), int'(lk2), int'(lp2), int'(mp2), int'(total2));
  end

  task automatic step(input bit v, input bit zz, input bit clr);
    @(negedge clk);
    z_valid = v;
    z       = zz;
    clear   = clr;
    @(posedge clk);
    q0.push_back(model(0, v, zz, clr));
    q1.push_back(model(1, v, zz, clr));
    q2.push_back(model(2, v, zz, clr));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".run_cnt0"}, int'(run_cnt0), 0);
    chk({tag, ".run_cnt1"}, int'(run_cnt1), 0);
    chk({tag, ".run_cnt2"}, int'(run_cnt2), 0);
    chk({tag, ".total0"}, int'(total0), 0);
    chk({tag, ".total1"}, int'(total1), 0);
    chk({tag, ".total2"}, int'(total2), 0);
    chk({tag, ".locked"}, int'(lk0) + int'(lk1) + int'(lk2), 0);
    chk({tag, ".lock_pulse"}, int'(lp0) + int'(lp1) + int'(lp2), 0);
    chk({tag, ".mismatch_pulse"}, int'(mp0) + int'(mp1) + int'(mp2), 0);
  endtask

  // Asserts reset between clock edges, checks outputs clear at once and stay
  // clear while inputs toggle, then releases at a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero({tag, ".async"});
    repeat (3) begin
      @(negedge clk);
      z       = 1'($urandom);
      z_valid = 1'($urandom);
      @(posedge clk);
      #1;
      check_zero({tag, ".hold"});
    end
    @(negedge clk);
    rst_n   = 1'b1;
    z_valid = 1'b0;
    clear   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_m[i] = 0;
      tot_m[i] = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      run_m[i] = 0;
      tot_m[i] = 0;
    end
    #1;
    check_zero("por");
    do_reset("rst0");

    // Lock on three matches, then reset mid-LOCK between edges.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    do_reset("rst_lock");

    // Break a run, then a mismatch while idle.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Gaps of invalid cycles inside a run, then lock exit.
    step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Saturation of run and total counters.
    repeat (9) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Clear wins over a concurrent valid match while locked.
    step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);

    // Randomized traffic with an occasional clear and one reset.
    repeat (200) step(($urandom % 10) < 8, ($urandom % 4) != 0, ($urandom % 32) == 0);
    do_reset("rst_rand");
    repeat (200) step(($urandom % 10) < 7, ($urandom % 3) != 0, ($urandom % 48) == 0);

    @(negedge clk);
    #1;
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    chk("drain2", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
